// File: rtl/stroke_write_arbiter.sv
// stroke_write_arbiter: shares the canvas write port between two brush-stamp sources and a full-canvas clear
module stroke_write_arbiter #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 180,
    parameter int ADDR_W = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              req0_valid_in,
    input  logic [9:0]        req0_x_in,
    input  logic [8:0]        req0_y_in,
    input  logic [3:0]        req0_color_in,
    input  logic [2:0]        req0_sw_in,
    output logic              req0_ready_out,
    input  logic              req1_valid_in,
    input  logic [9:0]        req1_x_in,
    input  logic [8:0]        req1_y_in,
    input  logic [3:0]        req1_color_in,
    input  logic [2:0]        req1_sw_in,
    output logic              req1_ready_out,
    input  logic              clear_in,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [3:0]        wr_data_out,
    output logic              busy_out,
    output logic              done_out
);
    typedef enum logic [1:0] {IDLE, STAMP, CLEAR} state_t;
    state_t             r_state;
    logic               r_last;
    logic               r_clr_pend;
    logic [1:0]         r_rec_vld;
    logic [25:0]        r_rec [2];
    logic [9:0]         r_x;
    logic [8:0]         r_y;
    logic [3:0]         r_color;
    logic [2:0]         r_r;
    logic signed [4:0]  r_dx;
    logic signed [4:0]  r_dy;
    logic [ADDR_W-1:0]  r_cnt;
    logic               w_idle;
    logic               w_acc;
    logic               w_sel;
    logic [25:0]        w_tup;
    logic               w_dup;
    logic signed [4:0]  w_r;
    logic signed [10:0] w_px;
    logic signed [10:0] w_py;
    logic               w_in;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_stamp_end;
    logic               w_clear_end;
    // r_last is the requester granted most recently; reset to 1 so requester 0 wins the first tie
    assign w_idle         = r_state == IDLE && !r_clr_pend;
    assign req0_ready_out = w_idle && req0_valid_in && (!req1_valid_in || r_last);
    assign req1_ready_out = w_idle && req1_valid_in && (!req0_valid_in || !r_last);
    assign w_acc          = req0_ready_out || req1_ready_out;
    assign w_sel          = req1_ready_out;
    assign w_tup          = w_sel ? {req1_x_in, req1_y_in, req1_color_in, req1_sw_in}
                                  : {req0_x_in, req0_y_in, req0_color_in, req0_sw_in};
    assign w_dup          = r_rec_vld[w_sel] && r_rec[w_sel] == w_tup;
    assign w_r            = $signed({2'b00, r_r});
    assign w_px           = $signed({1'b0, r_x}) + 11'(r_dx);
    assign w_py           = $signed({2'b00, r_y}) + 11'(r_dy);
    assign w_in           = !w_px[10] && !w_py[10] && w_px < 11'(WIDTH) && w_py < 11'(HEIGHT);
    assign w_addr         = ADDR_W'(w_py) * ADDR_W'(WIDTH) + ADDR_W'(w_px);
    assign w_stamp_end    = r_dx == w_r && r_dy == w_r;
    assign w_clear_end    = r_cnt == ADDR_W'(WIDTH * HEIGHT - 1);
    assign wr_en_out      = r_state == CLEAR || (r_state == STAMP && w_in);
    assign wr_addr_out    = r_state == CLEAR ? r_cnt : r_state == STAMP ? w_addr : '0;
    assign wr_data_out    = r_state == STAMP ? r_color : 4'd0;
    assign busy_out       = r_state != IDLE;
    assign done_out       = (r_state == STAMP && w_stamp_end) || (r_state == CLEAR && w_clear_end);
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_clr_pend <= 1'b0;
            r_rec_vld  <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_color    <= '0;
            r_r        <= '0;
            r_dx       <= '0;
            r_dy       <= '0;
            r_cnt      <= '0;
        end else begin
            r_clr_pend <= clear_in || (r_clr_pend && r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (r_clr_pend) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                    end else if (w_acc) begin
                        r_last                    <= w_sel;
                        {r_x, r_y, r_color, r_r}  <= w_tup;
                        if (!w_dup) begin
                            r_rec[w_sel]     <= w_tup;
                            r_rec_vld[w_sel] <= 1'b1;
                            r_state          <= STAMP;
                            r_dx             <= 5'd0 - {2'b00, w_tup[2:0]};
                            r_dy             <= 5'd0 - {2'b00, w_tup[2:0]};
                        end
                    end
                end
                STAMP: begin
                    if (r_dx == w_r) begin
                        r_dx <= -w_r;
                        if (r_dy == w_r) r_state <= IDLE;
                        else r_dy <= r_dy + 5'sd1;
                    end else r_dx <= r_dx + 5'sd1;
                end
                CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_clear_end) begin
                        r_state   <= IDLE;
                        r_rec_vld <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stroke_write_arbiter.sv
// tb_stroke_write_arbiter: directed checks of stamping, clipping, arbitration, duplicates, clear and reset
module tb_stroke_write_arbiter;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        req0_valid_in = 1'b0, req1_valid_in = 1'b0;
    logic [9:0]  req0_x_in = '0, req1_x_in = '0;
    logic [8:0]  req0_y_in = '0, req1_y_in = '0;
    logic [3:0]  req0_color_in = '0, req1_color_in = '0;
    logic [2:0]  req0_sw_in = '0, req1_sw_in = '0;
    logic        req0_ready_out, req1_ready_out;
    logic        clear_in = 1'b0;
    logic        wr_en_out;
    logic [15:0] wr_addr_out;
    logic [3:0]  wr_data_out;
    logic        busy_out, done_out;
    int checks = 0, errors = 0;
    int wq[$], dq[$];
    int n_done, done_at;
    stroke_write_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req0_valid_in(req0_valid_in), .req0_x_in(req0_x_in), .req0_y_in(req0_y_in),
        .req0_color_in(req0_color_in), .req0_sw_in(req0_sw_in), .req0_ready_out(req0_ready_out),
        .req1_valid_in(req1_valid_in), .req1_x_in(req1_x_in), .req1_y_in(req1_y_in),
        .req1_color_in(req1_color_in), .req1_sw_in(req1_sw_in), .req1_ready_out(req1_ready_out),
        .clear_in(clear_in), .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out),
        .wr_data_out(wr_data_out), .busy_out(busy_out), .done_out(done_out)
    );
    always #5 clk_in = ~clk_in;
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    // called at a negedge; returns at the negedge after the last observed cycle
    task automatic run_stamp(input int req, input int x, input int y, input int c, input int r,
                             input int cycles, input int clr_at);
        int waited = 0;
        wq.delete();
        dq.delete();
        n_done = 0;
        done_at = 0;
        if (req == 0) begin
            req0_x_in = 10'(x); req0_y_in = 9'(y); req0_color_in = 4'(c); req0_sw_in = 3'(r);
            req0_valid_in = 1'b1;
        end else begin
            req1_x_in = 10'(x); req1_y_in = 9'(y); req1_color_in = 4'(c); req1_sw_in = 3'(r);
            req1_valid_in = 1'b1;
        end
        #1;
        while (!(req == 0 ? req0_ready_out : req1_ready_out) && waited < 50) begin
            @(negedge clk_in);
            #1;
            waited++;
        end
        chk("accept_in_time", int'(waited < 50), 1);
        @(posedge clk_in);
        #1;
        req0_valid_in = 1'b0;
        req1_valid_in = 1'b0;
        @(negedge clk_in);
        for (int i = 1; i <= cycles; i++) begin
            clear_in = (i == clr_at);
            if (wr_en_out) begin
                wq.push_back(int'(wr_addr_out));
                dq.push_back(int'(wr_data_out));
            end
            if (done_out) begin
                n_done++;
                done_at = i;
            end
            @(negedge clk_in);
        end
        clear_in = 1'b0;
    endtask
    initial begin
        int exp1[9] = '{6089, 6090, 6091, 6409, 6410, 6411, 6729, 6730, 6731};
        int exp2[9] = '{0, 1, 2, 320, 321, 322, 640, 641, 642};
        int x0, x1, xa, g, k, bad, nd;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        chk("rst_wr_en", wr_en_out, 0);
        chk("rst_addr", wr_addr_out, 0);
        chk("rst_data", wr_data_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_ready0", req0_ready_out, 0);
        chk("rst_ready1", req1_ready_out, 0);
        run_stamp(0, 10, 20, 5, 1, 9, 0);
        chk("t1_nwr", wq.size(), 9);
        for (int i = 0; i < 9; i++) begin
            chk("t1_addr", wq[i], exp1[i]);
            chk("t1_data", dq[i], 5);
        end
        chk("t1_ndone", n_done, 1);
        chk("t1_done_at", done_at, 9);
        chk("t1_busy_after", busy_out, 0);
        run_stamp(1, 0, 0, 7, 2, 25, 0);
        chk("t2_nwr", wq.size(), 9);
        for (int i = 0; i < 9; i++) chk("t2_addr", wq[i], exp2[i]);
        chk("t2_done_at", done_at, 25);
        chk("t2_ndone", n_done, 1);
        x0 = 100;
        x1 = 200;
        req0_x_in = 10'(x0); req0_y_in = 9'd10; req0_color_in = 4'd1; req0_sw_in = 3'd0;
        req1_x_in = 10'(x1); req1_y_in = 9'd10; req1_color_in = 4'd2; req1_sw_in = 3'd0;
        req0_valid_in = 1'b1;
        req1_valid_in = 1'b1;
        #1;
        for (int n = 0; n < 4; n++) begin
            g = n % 2;
            chk("arb_ready0", req0_ready_out, int'(g == 0));
            chk("arb_ready1", req1_ready_out, int'(g == 1));
            xa = g == 0 ? x0 : x1;
            @(posedge clk_in);
            #1;
            if (g == 0) begin x0++; req0_x_in = 10'(x0); end
            else begin x1++; req1_x_in = 10'(x1); end
            @(negedge clk_in);
            chk("arb_wr_en", wr_en_out, 1);
            chk("arb_addr", wr_addr_out, 3200 + xa);
            chk("arb_data", wr_data_out, g + 1);
            chk("arb_done", done_out, 1);
            chk("arb_no_ready_busy", int'(req0_ready_out | req1_ready_out), 0);
            @(negedge clk_in);
            #1;
        end
        req0_valid_in = 1'b0;
        req1_valid_in = 1'b0;
        run_stamp(0, 50, 50, 3, 0, 1, 0);
        chk("dup1_nwr", wq.size(), 1);
        chk("dup1_addr", wq[0], 16050);
        chk("dup1_data", dq[0], 3);
        run_stamp(0, 50, 50, 3, 0, 1, 0);
        chk("dup2_nwr", wq.size(), 0);
        chk("dup2_ndone", n_done, 0);
        chk("dup2_busy", busy_out, 0);
        run_stamp(0, 50, 50, 4, 0, 1, 0);
        chk("dup3_nwr", wq.size(), 1);
        chk("dup3_addr", wq[0], 16050);
        chk("dup3_data", dq[0], 4);
        run_stamp(1, 100, 100, 9, 7, 225, 10);
        chk("big_nwr", wq.size(), 225);
        chk("big_first", wq[0], 29853);
        chk("big_last", wq[224], 34347);
        chk("big_done_at", done_at, 225);
        chk("clr_gap_busy", busy_out, 0);
        k = 0;
        bad = 0;
        nd = 0;
        for (int t = 0; t < 60000; t++) begin
            if (wr_en_out) begin
                if (int'(wr_addr_out) != k || wr_data_out != 4'd0) bad++;
                k++;
            end
            if (done_out) nd++;
            if (done_out) break;
            @(negedge clk_in);
        end
        chk("clr_nwr", k, 57600);
        chk("clr_bad", bad, 0);
        chk("clr_ndone", nd, 1);
        @(negedge clk_in);
        chk("clr_busy_after", busy_out, 0);
        chk("clr_done_after", done_out, 0);
        run_stamp(0, 50, 50, 4, 0, 1, 0);
        chk("post_clr_nwr", wq.size(), 1);
        chk("post_clr_addr", wq[0], 16050);
        run_stamp(0, 30, 30, 2, 3, 5, 0);
        chk("rs_nwr_before", wq.size(), 5);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("rs_wr_en", wr_en_out, 0);
        chk("rs_busy", busy_out, 0);
        rst_in = 1'b0;
        run_stamp(0, 30, 30, 2, 3, 49, 0);
        chk("rs_nwr", wq.size(), 49);
        chk("rs_first", wq[0], 8667);
        chk("rs_last", wq[48], 10593);
        chk("rs_done_at", done_at, 49);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stroke_write_arbiter.md
Name: stroke_write_arbiter

Overview:
- Shares the single write port of the scaled canvas RAM between two stroke sources: requester 0 is the local cursor, and requester 1 is the remote stroke arriving from the differential link.
- Each accepted request is expanded into a square brush stamp, swept in row-major order one pixel per cycle, with clipping to the canvas.
- Also sequences a full-canvas clear.
- Sits between the user-input/communication logic and the canvas RAM in the pixel clock domain.

Parameters:
- WIDTH, 320, canvas width in pixels.
- HEIGHT, 180, canvas height in pixels.
- ADDR_W, 16, write address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.

Ports:
- clk_in  input  1  pixel clock; the only clock.
- rst_in  input  1  synchronous, active-high reset.
- req0_valid_in  input  1  requester 0 has a stamp.
- req0_x_in  input  10  requester 0 centre x.
- req0_y_in  input  9  requester 0 centre y.
- req0_color_in  input  4  requester 0 palette index.
- req0_sw_in  input  3  requester 0 brush radius r.
- req0_ready_out  output  1  requester 0 accepted this cycle when valid is also high.
- req1_valid_in / req1_x_in / req1_y_in / req1_color_in / req1_sw_in / req1_ready_out  same widths and meaning as requester 0, for requester 1.
- clear_in  input  1  pulse requesting a full-canvas clear.
- wr_en_out  output  1  canvas write strobe.
- wr_addr_out  output  ADDR_W  write address, y*WIDTH + x.
- wr_data_out  output  4  write colour.
- busy_out  output  1  high whenever state != IDLE.
- done_out  output  1  one-cycle pulse on completion of a stamp or clear.

Behaviour:
- Reset values: all outputs 0. State IDLE. Round-robin pointer set so requester 0 wins the first tie. clear_pending = 0. Both last-stamp records invalid.
- States:
  - IDLE: arbitrate.
  - STAMP: sweep brush pixels.
  - CLEAR: sweep the whole canvas.
- Priority in IDLE: clear_pending first, then requests. Ready outputs are only ever high in IDLE, and at most one is high per cycle.
- clear_in pulses arriving in any state set clear_pending. It is cleared when CLEAR is entered. Multiple pulses collapse into one clear.
- Request arbitration: if only one requester is valid, it is granted. If both are valid, grant the one not granted last; the pointer updates only on acceptance. readyN_out is combinational from state, pointer and valids.
- Acceptance (valid && ready in cycle N):
  - Latch x, y, colour, r.
  - If the latched tuple equals that requester's last-stamp record, discard it: stay IDLE, no writes, done_out stays low.
  - Otherwise update the record and go to STAMP with dx = dy = -r.
- STAMP:
  - Occupies cycles N+1 .. N+S, where S = (2r+1)^2. r=0 gives 1 pixel; r=7 gives 225.
  - Order: dx increments fastest from -r to +r, then dy increments.
  - Each cycle, compute px = x+dx and py = y+dy as signed 11-bit values.
  - wr_en_out is high only if 0 <= px < WIDTH and 0 <= py < HEIGHT. Otherwise the cycle is consumed with wr_en_out low, so latency is fixed regardless of clipping.
  - wr_data_out = latched colour; wr_addr_out = py*WIDTH + px.
  - done_out pulses in cycle N+S. State is IDLE in cycle N+S+1, and a new acceptance is possible that cycle.
- CLEAR:
  - Entered from IDLE at cycle M.
  - Writes colour 0 to addresses 0 .. WIDTH*HEIGHT-1, ascending, in cycles M+1 .. M+WIDTH*HEIGHT.
  - done_out pulses on the last write.
  - Both last-stamp records are invalidated on exit.
- Write outputs never combinationally depend on req* inputs.
- rst_in mid-STAMP or mid-CLEAR: the operation is abandoned, wr_en_out is 0 in the following cycle, and everything returns to reset values.
- Inputs held valid while not ready are simply held off; there is no timeout.

Test Plan:
- Single stamp: after reset, req0 x=10 y=20 r=1 colour=5, accepted cycle N -> 9 writes in N+1..N+9 with addresses 6089, 6090, 6091, 6409, 6410, 6411, 6729, 6730, 6731 and data 5; done_out at N+9; busy_out low at N+10.
- Corner clip: req1 x=0 y=0 r=2 -> 25 STAMP cycles, exactly 9 writes at addresses 0, 1, 2, 320, 321, 322, 640, 641, 642; done_out on cycle 25.
- Arbitration: both valid with r=0 and distinct tuples, held continuously -> grants alternate 0, 1, 0, 1; each grant produces a 1-pixel stamp at the correct address.
- Duplicate suppression: req0 x=50 y=50 r=0 colour=3 sent twice -> one write at address 16050 only; second acceptance gives no write and no done_out; changing colour to 4 writes again.
- Clear: clear_in pulsed during a 225-cycle stamp -> stamp completes, then 57600 writes of 0 to addresses 0..57599, done_out once; a previously-sent duplicate req0 tuple writes again afterwards.
- Reset mid-stamp: rst_in asserted at cycle 5 of an r=3 stamp -> wr_en_out 0 next cycle, busy_out 0; the same tuple resubmitted performs the full 49-cycle stamp.
